// File: rtl/vga_pkg.sv
// Shared types and helpers for the framebuffer scan-out engine.
package vga_pkg;

  typedef enum logic {
    MODE_GRAY   = 1'b0,
    MODE_RGB332 = 1'b1
  } pix_mode_t;

  // Replicate each channel's MSBs so full-scale codes reach 8'hFF.
  function automatic logic [23:0] expand_rgb332(input logic [7:0] q);
    return {q[7:5], q[7:5], q[7:6], q[4:2], q[4:2], q[4:3], {4{q[1:0]}}};
  endfunction

  function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters and the raw, undelayed timing strobes derived from them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          active_o,
  output logic          hsync_raw_o,
  output logic          vsync_raw_o,
  output logic          frame_start_o,
  output logic          boundary_o
);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;

  assign h_last = (32'(hcnt_q) == H_TOTAL - 1);
  assign v_last = (32'(vcnt_q) == V_TOTAL - 1);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      if (v_last) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o        = hcnt_q;
  assign vcnt_o        = vcnt_q;
  assign active_o      = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
  assign hsync_raw_o   = !((32'(hcnt_q) >= H_ACTIVE + H_FP) &&
                           (32'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC));
  assign vsync_raw_o   = !((32'(vcnt_q) >= V_ACTIVE + V_FP) &&
                           (32'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC));
  assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
  assign boundary_o    = h_last && v_last;

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out: VGA timing, RAM address generation with upscaling,
// read-latency alignment, pixel expansion and tear-free base swapping.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int ADDR_W     = 19,
  parameter int RD_LAT     = 1,
  parameter int SCALE_LOG2 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              swap_req,
  input  logic              mode,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_q,
  output logic              swap_done,
  output logic              frame_start,
  output logic              hsync,
  output logic              vsync,
  output logic              sync_b,
  output logic              blank_b,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);

  localparam int HW    = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW    = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int DLY   = RD_LAT + 1;
  localparam int SMASK = (1 << SCALE_LOG2) - 1;
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, hs_raw, vs_raw, fs_raw, boundary;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk_i         (clk),
    .rst_i         (rst),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .active_o      (active),
    .hsync_raw_o   (hs_raw),
    .vsync_raw_o   (vs_raw),
    .frame_start_o (fs_raw),
    .boundary_o    (boundary)
  );

  logic [ADDR_W-1:0] line_addr_q, cur_base_q, pend_base_q, fb_addr_q;
  logic              pending_q, swap_done_q;
  pix_mode_t         mode_q;
  logic              line_end;
  logic [ADDR_W-1:0] hoff;

  // The last pixel of the final replicated line of a source row advances to the next row.
  assign line_end = active && (32'(hcnt) == H_ACTIVE - 1) && ((32'(vcnt) & SMASK) == SMASK);
  assign hoff     = ADDR_W'(32'(hcnt) >> SCALE_LOG2);

  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr_q <= '0;
      cur_base_q  <= '0;
      pend_base_q <= '0;
      fb_addr_q   <= '0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      mode_q      <= MODE_GRAY;
    end else begin
      fb_addr_q   <= active ? (line_addr_q + hoff) : line_addr_q;
      swap_done_q <= 1'b0;
      if (boundary) begin
        mode_q      <= pix_mode_t'(mode);
        line_addr_q <= pending_q ? pend_base_q : cur_base_q;
        if (pending_q) begin
          cur_base_q  <= pend_base_q;
          pending_q   <= 1'b0;
          swap_done_q <= 1'b1;
        end
      end else if (line_end) begin
        line_addr_q <= line_addr_q + LINE_STEP;
      end
      // Placed last so a request in the boundary cycle re-arms for the next frame.
      if (swap_req) begin
        pend_base_q <= fb_base;
        pending_q   <= 1'b1;
      end
    end
  end

  logic [DLY-1:0] act_dly_q, hs_dly_q, vs_dly_q, fs_dly_q;
  logic [23:0]    pix_d;
  logic           hsync_q, vsync_q, sync_b_q, blank_b_q, frame_start_q;
  logic [23:0]    pix_q;

  always_comb begin
    pix_d = 24'h000000;
    if (!act_dly_q[DLY-1]) begin
      pix_d = 24'h000000;
    end else if (mode_q == MODE_RGB332) begin
      pix_d = expand_rgb332(fb_q);
    end else begin
      pix_d = {fb_q, fb_q, fb_q};
    end
  end

  // Control strobes wait out address register plus RAM latency, then meet fb_q at the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_dly_q     <= '0;
      hs_dly_q      <= '1;
      vs_dly_q      <= '1;
      fs_dly_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      sync_b_q      <= 1'b1;
      blank_b_q     <= 1'b0;
      frame_start_q <= 1'b0;
      pix_q         <= 24'h000000;
    end else begin
      act_dly_q     <= {act_dly_q[DLY-2:0], active};
      hs_dly_q      <= {hs_dly_q[DLY-2:0], hs_raw};
      vs_dly_q      <= {vs_dly_q[DLY-2:0], vs_raw};
      fs_dly_q      <= {fs_dly_q[DLY-2:0], fs_raw};
      hsync_q       <= hs_dly_q[DLY-1];
      vsync_q       <= vs_dly_q[DLY-1];
      sync_b_q      <= hs_dly_q[DLY-1] & vs_dly_q[DLY-1];
      blank_b_q     <= act_dly_q[DLY-1];
      frame_start_q <= fs_dly_q[DLY-1];
      pix_q         <= pix_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign swap_done   = swap_done_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_b      = sync_b_q;
  assign blank_b     = blank_b_q;
  assign r           = pix_q[23:16];
  assign g           = pix_q[15:8];
  assign b           = pix_q[7:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Randomized bench for two scan-out configurations (plain and 2x upscale) against a frame-level model.
module tb_vga_fb_scanout;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int LAT_A = 1, LAT_B = 2, SC_A = 0, SC_B = 1, AW_A = 10, AW_B = 8;
  localparam int NCYC = 12000;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       sb;
    logic       bl;
    logic       fs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pins_t;

  localparam pins_t RST_PINS = pins_t'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swap_req = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] fb_base = 10'd0;

  logic [9:0] addr_a;
  logic [7:0] addr_b;
  logic [7:0] qa1, qb1, qb2;
  logic       sd_a, fs_a, hs_a, vs_a, sb_a, bl_a;
  logic       sd_b, fs_b, hs_b, vs_b, sb_b, bl_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  pins_t      pa, pb;

  always #5 clk = ~clk;

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(AW_A), .RD_LAT(LAT_A), .SCALE_LOG2(SC_A)
  ) dut_a (
    .clk(clk), .rst(rst), .fb_base(fb_base), .swap_req(swap_req), .mode(mode),
    .fb_addr(addr_a), .fb_q(qa1), .swap_done(sd_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a), .sync_b(sb_a), .blank_b(bl_a),
    .r(r_a), .g(g_a), .b(b_a)
  );

  vga_fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(AW_B), .RD_LAT(LAT_B), .SCALE_LOG2(SC_B)
  ) dut_b (
    .clk(clk), .rst(rst), .fb_base(fb_base[7:0]), .swap_req(swap_req), .mode(mode),
    .fb_addr(addr_b), .fb_q(qb2), .swap_done(sd_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b), .sync_b(sb_b), .blank_b(bl_b),
    .r(r_b), .g(g_b), .b(b_b)
  );

  assign pa = {hs_a, vs_a, sb_a, bl_a, fs_a, r_a, g_a, b_a};
  assign pb = {hs_b, vs_b, sb_b, bl_b, fs_b, r_b, g_b, b_b};

  // RAM contents: a constant fill or the address XOR a key, changed only during vertical blanking.
  logic       fill_sel = 1'b0;
  logic [7:0] fill = 8'h00;
  logic [7:0] key  = 8'h00;

  function automatic logic [7:0] ram_data(input logic [9:0] a);
    return fill_sel ? fill : (a[7:0] ^ key);
  endfunction

  always @(posedge clk) begin
    qa1 <= ram_data(addr_a);
    qb1 <= ram_data({2'b00, addr_b});
    qb2 <= qb1;
  end

  // Model state: counters of the current cycle, per-instance frame base, pins ring indexed by cycle.
  int    h, v, fr, pc;
  int    base[2];
  int    exp_addr[2];
  int    pend_base;
  logic  pending, mode_m, exp_swap, chk_en;
  pins_t ring[2][8];
  int    n_chk, n_err;
  int    first_a, sd_cnt, drst_p;
  logic  drst_done;

  function automatic int pl(input int i);
    return (i == 0) ? LAT_A + 2 : LAT_B + 2;
  endfunction

  function automatic int amask(input int i);
    return (i == 0) ? (1 << AW_A) - 1 : (1 << AW_B) - 1;
  endfunction

  function automatic int m_addr(input int i, input int hh, input int vv);
    int s, step, adv, a;
    s    = (i == 0) ? SC_A : SC_B;
    step = HA >> s;
    if (hh < HA && vv < VA) begin
      a = base[i] + (vv >> s) * step + (hh >> s);
    end else begin
      adv = ((vv < VA) ? vv : VA) >> s;
      if (vv < VA && hh >= HA && (vv % (1 << s)) == (1 << s) - 1) adv++;
      a = base[i] + adv * step;
    end
    return a & amask(i);
  endfunction

  function automatic pins_t m_pins(input int i, input int hh, input int vv);
    pins_t x;
    logic [7:0] q;
    int r3, g3, b2;
    x.hs = !(hh >= HA + HF && hh < HA + HF + HS);
    x.vs = !(vv >= VA + VF && vv < VA + VF + VS);
    x.sb = x.hs & x.vs;
    x.bl = (hh < HA) && (vv < VA);
    x.fs = (hh == 0) && (vv == 0);
    q = ram_data(10'(m_addr(i, hh, vv)));
    r3 = int'(q[7:5]);
    g3 = int'(q[4:2]);
    b2 = int'(q[1:0]);
    if (!x.bl) begin
      x.r = 8'h00; x.g = 8'h00; x.b = 8'h00;
    end else if (mode_m) begin
      x.r = 8'((r3 * 510 + 7) / 14);
      x.g = 8'((g3 * 510 + 7) / 14);
      x.b = 8'(b2 * 85);
    end else begin
      x.r = q; x.g = q; x.b = q;
    end
    return x;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s inst%0d cycle %0d got %h expected %h", nm, inst, pc, got, expv);
    end
  endtask

  initial begin
    h = 0; v = 0; fr = 0; pc = 0; pending = 1'b0; pend_base = 0; mode_m = 1'b0;
    exp_swap = 1'b0; chk_en = 1'b0; n_chk = 0; n_err = 0;
    first_a = -1; sd_cnt = 0; drst_p = -10; drst_done = 1'b0;
    base[0] = 0; base[1] = 0; exp_addr[0] = 0; exp_addr[1] = 0;

    while (pc < NCYC) begin
      @(negedge clk);
      if (chk_en) begin
        chk("pins", 0, 32'(pa), 32'(ring[0][pc % 8]));
        chk("pins", 1, 32'(pb), 32'(ring[1][pc % 8]));
        chk("fb_addr", 0, 32'(addr_a), 32'(exp_addr[0]));
        chk("fb_addr", 1, 32'(addr_b), 32'(exp_addr[1]));
        chk("swap_done", 0, 32'(sd_a), 32'(exp_swap));
        chk("swap_done", 1, 32'(sd_b), 32'(exp_swap));
        if (first_a < 0 && !hs_a) first_a = pc;
        if (sd_a && ((fr == 4 && !(h == 0 && v == 0)) || (fr == 5 && h == 0 && v == 0))) sd_cnt++;
        // Hand-derived expectations for the undisturbed first frames.
        if (pc == 300) chk("first_hsync_fall", 0, 32'(first_a), 32'(3 + HA + HF + LAT_A + 2));
        if (pc == 3 + HT + 1) chk("addr_row1", 0, 32'(addr_a), 32'd16);
        if (pc == 3 + 2 * HT + 1) chk("addr_row2_scaled", 1, 32'(addr_b), 32'd8);
        if (pc == 3 + 7 * HT + 15 + 1) begin
          chk("addr_last_px", 0, 32'(addr_a), 32'd127);
          chk("addr_last_px_scaled", 1, 32'(addr_b), 32'd31);
        end
        if (pc == 345) chk("rgb332_E0", 0, {8'h00, r_a, g_a, b_a}, 32'h00FF0000);
        if (pc == 634) chk("rgb332_03", 1, {8'h00, r_b, g_b, b_b}, 32'h000000FF);
        if (fr == 5 && h == 1 && v == 0) begin
          chk("swap_base", 0, 32'(addr_a), 32'h155);
          chk("swap_base", 1, 32'(addr_b), 32'h55);
        end
        if (fr == 5 && h == 0 && v == 1) chk("swap_done_count", 0, 32'(sd_cnt), 32'd1);
        if (pc == drst_p + 1) begin
          chk("reset_pins", 0, 32'(pa), 32'(RST_PINS));
          chk("reset_addr", 0, 32'(addr_a), 32'd0);
        end
      end

      // Stimulus for this cycle.
      rst = 1'b0;
      swap_req = 1'b0;
      if (pc < 3) rst = 1'b1;
      else if (fr >= 8 && $urandom_range(0, 2999) == 0) rst = 1'b1;
      if (fr == 10 && !drst_done && v == 5 && h == 7) begin
        rst = 1'b1; drst_done = 1'b1; drst_p = pc;
      end
      if (!rst) begin
        if (fr == 4) begin
          if (v == 2 && h == 5) begin swap_req = 1'b1; fb_base = 10'd300; end
          else if (v == 6 && h == 1) begin swap_req = 1'b1; fb_base = 10'h155; end
        end else if (fr == 10 && v == 3 && h == 0) begin
          swap_req = 1'b1; fb_base = 10'h2AA;
        end else if (fr >= 2 && $urandom_range(0, 199) == 0) begin
          swap_req = 1'b1; fb_base = 10'($urandom);
        end
      end
      if (fr == 0) mode = 1'b1;
      else if (fr == 1 && v == 1 && h == 0) mode = 1'b0;
      else if (fr == 1 && v == VA + 1 && h == 0) mode = 1'b1;
      else if (fr >= 3 && $urandom_range(0, 39) == 0) mode = ~mode;
      if (v == VA && h == 0) begin
        if (fr == 0) begin fill_sel = 1'b1; fill = 8'hE0; end
        else if (fr == 1) begin fill_sel = 1'b1; fill = 8'h03; end
        else begin
          fill_sel = ($urandom_range(0, 3) == 0);
          fill = 8'($urandom);
          key  = 8'($urandom);
        end
      end

      // Model step for this cycle.
      if (rst) begin
        h = 0; v = 0; mode_m = 1'b0; pending = 1'b0; pend_base = 0; exp_swap = 1'b0;
        for (int i = 0; i < 2; i++) begin
          base[i] = 0;
          exp_addr[i] = 0;
          for (int k = 1; k <= pl(i); k++) ring[i][(pc + k) % 8] = RST_PINS;
        end
        chk_en = 1'b1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          ring[i][(pc + pl(i)) % 8] = m_pins(i, h, v);
          exp_addr[i] = m_addr(i, h, v);
        end
        exp_swap = 1'b0;
        if (h == HT - 1 && v == VT - 1) begin
          mode_m = mode;
          if (pending) begin
            base[0] = pend_base & amask(0);
            base[1] = pend_base & amask(1);
            pending = 1'b0;
            exp_swap = 1'b1;
          end
          fr++;
        end
        if (swap_req) begin
          pending = 1'b1;
          pend_base = int'(fb_base);
        end
        if (h == HT - 1) begin
          h = 0;
          v = (v == VT - 1) ? 0 : v + 1;
        end else begin
          h++;
        end
      end
      pc++;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
Parametrised framebuffer scan-out engine, the successor to the fixed 640x480 VGA controller. It generates VGA timing from a timing parameter set and drives the read port of the dual-port framebuffer RAM. It compensates for the RAM's read latency and expands 8-bit pixels in grayscale or RGB332 mode. It also supports tear-free double buffering via a base-address swap at the frame boundary, and integer pixel upscaling. It runs on the pixel clock (vgaclk) and sits between the framebuffer RAM and the monitor pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
ADDR_W, 19, framebuffer address width
RD_LAT, 1, RAM read latency in clocks (1 or 2)
SCALE_LOG2, 0, upscale factor 2^SCALE_LOG2 (0..2); H_ACTIVE and V_ACTIVE must be divisible by 2^SCALE_LOG2

Ports:
clk  in  1  pixel clock
rst  in  1  reset
fb_base  in  ADDR_W  requested buffer base address, sampled with swap_req
swap_req  in  1  single-cycle request to switch to fb_base
mode  in  1  0 = grayscale, 1 = RGB332
fb_addr  out  ADDR_W  framebuffer read address
fb_q  in  8  RAM read data, valid RD_LAT clocks after fb_addr
swap_done  out  1  one-cycle pulse when the swap takes effect
frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0
hsync, vsync  out  1  active-low syncs
sync_b  out  1  hsync AND vsync
blank_b  out  1  high in the visible area
r, g, b  out  8  colour

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: hcnt=0, vcnt=0, fb_addr=0, cur_base=0, swap pending cleared, latched mode=0, whole delay pipeline cleared. Outputs: hsync=1, vsync=1, sync_b=1, blank_b=0, r/g/b=0, swap_done=0, frame_start=0.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise from the V parameters.
- Counters: hcnt wraps H_TOTAL-1 -> 0. vcnt increments on hcnt wrap and wraps V_TOTAL-1 -> 0.
- Raw timing signals (counter domain):
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hsync_raw = 0 for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_raw is the same form on vcnt.
- Addressing: multiplier-free.
  - line_addr <= cur_base at frame boundary.
  - At hcnt = H_ACTIVE-1 on an active line whose low SCALE_LOG2 bits of vcnt are all ones: line_addr <= line_addr + (H_ACTIVE >> SCALE_LOG2).
  - fb_addr is registered as line_addr + (hcnt >> SCALE_LOG2) when active, and holds line_addr otherwise. fb_addr therefore lags the counters by 1 clock.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Alignment:
  - active, hsync_raw, vsync_raw and frame_start are delayed RD_LAT+1 stages; r/g/b are registered from fb_q.
  - All pin outputs change together. Counter-to-pin latency = RD_LAT+2 clocks.
- Colour:
  - Blanked (delayed active = 0): r/g/b = 0.
  - Grayscale: r = g = b = q.
  - RGB332: r = {q[7:5], q[7:5], q[7:6]}, g = {q[4:2], q[4:2], q[4:3]}, b = {q[1:0] x4}.
  - mode is latched at the frame boundary only; mid-frame changes are ignored.
- Double buffering:
  - swap_req=1 latches fb_base into pend_base and sets pending.
  - A second request before the boundary overwrites pend_base; only one swap_done results.
  - At the boundary cycle (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) with pending set: cur_base <= pend_base, pending <= 0, swap_done=1 for 1 clock.
  - A swap_req arriving in the boundary cycle itself is deferred to the next frame.
- Reset mid-operation: all state returns to reset values on the next clock; a pending swap is discarded.

Decomposition:
- Package vga_pkg: pix_mode_t enum {MODE_GRAY, MODE_RGB332}, function expand_rgb332, and a function computing totals from timing parameters.
- Sub-module vga_timing: hcnt/vcnt, active, raw syncs, frame-boundary strobe. Parametrised by the 8 timing parameters.

Test Plan:
1. Default params, RD_LAT=1, release rst -> first hsync fall 659 clocks later (656 + 3); low for 96 clocks; hsync period 800; vsync period 525 lines; sync_b = hsync & vsync.
2. RAM model returning fb_q = addr[7:0], mode=0 -> first blank_b=1 cycle shows r=g=b=0x00; pixel (1,0) shows 0x01; fb_addr for (0,1) = 640, for (639,479) = 307199.
3. mode=1, frame filled with 8'hE0 -> r=FF, g=00, b=00; 8'h1C -> g=FF; 8'h03 -> b=FF. A mode toggle mid-frame takes effect only on the next frame.
4. swap_req with fb_base=307200 at line 100 -> current frame unchanged; swap_done pulses at the boundary; next frame's first fb_addr = 307200. A second request before the boundary (fb_base=0) wins; exactly one swap_done.
5. SCALE_LOG2=1 -> fb_addr sequence 0,0,1,1,...; each address row repeats for 2 lines; pixel (639,479) reads 76799.
6. rst asserted at hcnt=300, vcnt=200 with a swap pending -> next clock all outputs at reset values; timing restarts from (0,0); no swap_done; cur_base = 0.
